div_iter: RTL and testbench



---
 rtl/div_iter.sv | 134 +++++++++++++
 tb/tb_div_iter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// Iterative 32-bit radix-2 restoring divider (DIV/DIVU), result {rem, quo}.
// Optional `DIV_EARLY_OUT_EN: skip iterations when |dividend| < |divisor|.
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [64:0] w;
    logic [31:0] b_abs;
    logic        q_neg;
    logic        r_neg;
    logic [63:0] res_q;
`ifdef DIV_EARLY_OUT_EN
    logic        early;
`endif

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [64:0] w_sh;
    logic [32:0] diff;
    logic [64:0] w_nxt;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        a_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
        b_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    end

    // Trial subtraction on the upper 33 bits; bit 32 of diff is the borrow.
    always_comb begin
        w_sh  = {w[63:0], 1'b0};
        diff  = w_sh[64:32] - {1'b0, b_abs};
        w_nxt = w_sh;
        if (!diff[32]) begin
            w_nxt = {diff, w_sh[31:1], 1'b1};
        end
        quo_fix = q_neg ? (~w_nxt[31:0] + 32'd1) : w_nxt[31:0];
        rem_fix = r_neg ? (~w_nxt[63:32] + 32'd1) : w_nxt[63:32];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FREE;
            cnt      <= 5'd0;
            w        <= 65'd0;
            b_abs    <= 32'd0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            res_q    <= 64'd0;
            result_o <= 64'd0;
            ready_o  <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            early    <= 1'b0;
`endif
        end else begin
            unique case (state)
                FREE: begin
                    ready_o  <= 1'b0;
                    result_o <= 64'd0;
                    if (start_i && !annul_i) begin
                        if (opdata2_i == 32'd0) begin
                            state <= BYZERO;
                        end else begin
                            state <= ON;
                            b_abs <= b_mag;
                            q_neg <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                            r_neg <= signed_div_i & opdata1_i[31];
                            cnt   <= 5'd0;
                            w     <= {33'd0, a_mag};
`ifdef DIV_EARLY_OUT_EN
                            early <= (a_mag < b_mag);
`endif
                        end
                    end
                end
                BYZERO: begin
                    if (annul_i || !start_i) begin
                        state <= FREE;
                    end else begin
                        state <= END;
                        res_q <= 64'd0;
                    end
                end
                ON: begin
                    if (annul_i || !start_i) begin
                        state <= FREE;
`ifdef DIV_EARLY_OUT_EN
                    end else if (early) begin
                        // Quotient is zero; remainder restores the original dividend.
                        state <= END;
                        res_q <= {(r_neg ? (~w[31:0] + 32'd1) : w[31:0]), 32'd0};
`endif
                    end else begin
                        w   <= w_nxt;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state <= END;
                            res_q <= {rem_fix, quo_fix};
                        end
                    end
                end
                END: begin
                    if (!start_i) begin
                        state    <= FREE;
                        ready_o  <= 1'b0;
                        result_o <= 64'd0;
                    end else begin
                        ready_o  <= 1'b1;
                        result_o <= res_q;
                    end
                end
                default: state <= FREE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed testbench for div_iter: latency, signed/unsigned results, annul, reset.
// Latency of the early-out case follows `DIV_EARLY_OUT_EN when defined.
module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int total = 0;
    int bad = 0;

    div_iter dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Edge 0 of the loop is edge k (start first sampled); latency is the
    // index of the first edge after which ready_o is high (41 = timeout).
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
        int lat;
        @(negedge clk);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        lat = 41;
        for (int i = 0; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 3) begin
                opdata1_i = 32'hDEAD_BEEF;
                opdata2_i = 32'h0000_0001;
            end
            if (ready_o === 1'b1) begin
                lat = i;
                break;
            end
        end
        chk_int({tag, "_lat"}, lat, exp_lat);
        chk64({tag, "_res"}, result_o, exp_res);
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk64({tag, "_drop"}, {63'd0, ready_o}, 64'd0);
        @(negedge clk);
    endtask

    int saw;

    initial begin
        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk64("rst_ready", {63'd0, ready_o}, 64'd0);
        chk64("rst_result", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div("divu_100_7", 1'b0, 32'd100, 32'd7, 33, {32'h2, 32'hE});
        do_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'h1, 32'hFFFF_FFFD});
        do_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000});
        do_div("divu_5_0", 1'b0, 32'd5, 32'd0, 2, 64'd0);
        do_div("divu_max", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'h0, 32'hFFFF_FFFF});

        // Annul at edge k+10.
        @(negedge clk);
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(negedge clk);
        annul_i = 1'b0;
        start_i = 1'b0;
        saw = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o === 1'b1) saw++;
        end
        chk_int("annul_no_ready", saw, 0);
        do_div("divu_9_4", 1'b0, 32'd9, 32'd4, 33, {32'h1, 32'h2});

        // Asynchronous reset mid-divide.
        @(negedge clk);
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        repeat (15) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk64("async_rst_ready", {63'd0, ready_o}, 64'd0);
        chk64("async_rst_result", result_o, 64'd0);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        do_div("divu_20_6", 1'b0, 32'd20, 32'd6, 33, {32'h2, 32'h3});

`ifdef DIV_EARLY_OUT_EN
        do_div("divu_3_10", 1'b0, 32'd3, 32'd10, 2, {32'h3, 32'h0});
        do_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 2, {32'hFFFF_FFFD, 32'h0});
`else
        do_div("divu_3_10", 1'b0, 32'd3, 32'd10, 33, {32'h3, 32'h0});
        do_div("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 33, {32'hFFFF_FFFD, 32'h0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
